shifter32_seq: RTL



---
 rtl/alu_defs.sv | 15 +
 rtl/shifter32_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_defs.sv
// Shared ALU definitions: shift operation codes and the iterative shifter's
// state encoding, common to the barrel shifter, the sequential shifter and control.
package alu_defs;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b01;
  localparam logic [1:0] ALUC_SLL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shifter32_seq.sv
// Iterative shifter: one bit position per clock under a start/busy/done
// handshake, producing the same result, carry and negative flag as the barrel shifter.
module shifter32_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SAW   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SAW-1:0]   b,
  input  logic [1:0]       aluc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             negative
);

  shift_state_e     r_state;
  shift_state_e     w_next_state;
  logic [SAW-1:0]   r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_c;
  logic             r_carry;
  logic [WIDTH:0]   w_step;
  logic             w_last_step;
  logic             w_accept;

  // One-position shift; the MSB of the return value is the bit shifted out.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       op);
    logic [WIDTH:0] res;
    case (op)
      ALUC_SRA: res = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      ALUC_SRL: res = {v[0], 1'b0, v[WIDTH-1:1]};
      default:  res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
    endcase
    return res;
  endfunction

  assign w_step      = shift_step(r_c, r_op);
  assign w_last_step = (r_cnt == {{(SAW-1){1'b0}}, 1'b1});
  assign w_accept    = (r_state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a zero shift amount skips straight to DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (b == {SAW{1'b0}}) begin
            w_next_state = DONE;
          end else begin
            w_next_state = SHIFT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_last_step) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture on accept, then one shift per cycle while in SHIFT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_c     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {SAW{1'b0}};
      r_op    <= 2'b00;
    end else if (w_accept) begin
      r_c     <= a;
      r_carry <= 1'b0;
      r_cnt   <= b;
      r_op    <= aluc;
    end else if (r_state == SHIFT) begin
      r_c     <= w_step[WIDTH-1:0];
      r_carry <= w_step[WIDTH];
      r_cnt   <= r_cnt - {{(SAW-1){1'b0}}, 1'b1};
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign c        = r_c;
  assign carry    = r_carry;
  assign negative = r_c[WIDTH-1];

endmodule
